// File: rtl/bus_arbiter_rr_n_if.sv
// bus_arbiter_rr_n_if: request/lock/grant bundle between the bus masters and the arbiter
interface bus_arbiter_rr_n_if #(
    parameter int MASTERS     = 4,
    parameter int OWNER_WIDTH = 2
);
    logic [MASTERS-1:0]     request_;
    logic [MASTERS-1:0]     lock_;
    logic                   mode;
    logic [MASTERS-1:0]     grant_;
    logic [OWNER_WIDTH-1:0] owner;
    logic                   preempt;

    modport master (output request_, lock_, mode, input grant_, owner, preempt);
    modport slave  (input request_, lock_, mode, output grant_, owner, preempt);
endinterface

// File: rtl/bus_arbiter_rr_n.sv
// bus_arbiter_rr_n: N-master round-robin/fixed-priority arbiter with tenure preemption and lock
module bus_arbiter_rr_n #(
    parameter int MASTERS      = 4,
    parameter int OWNER_WIDTH  = 2,
    parameter int MAX_TENURE   = 16,
    parameter int TENURE_WIDTH = 5
) (
    input logic               clock,
    input logic               reset,
    bus_arbiter_rr_n_if.slave bus
);
    localparam logic [TENURE_WIDTH-1:0] LIM = TENURE_WIDTH'(MAX_TENURE == 0 ? 0 : MAX_TENURE - 1);

    logic [OWNER_WIDTH-1:0]  owner_q, owner_d, next_owner, idx;
    logic [TENURE_WIDTH-1:0] tenure_q, tenure_d;
    logic [MASTERS-1:0]      grant_q, grant_d, others;
    logic                    preempt_q, preempt_d, owner_req, owner_lock, contended;

    // The owner is masked out, so a search only ever hands the bus to someone else.
    assign others     = ~bus.request_ & ~(MASTERS'(1) << owner_q);
    assign owner_req  = ~bus.request_[owner_q];
    assign owner_lock = ~bus.lock_[owner_q];
    assign contended  = owner_req && |others;

    always_comb begin
        next_owner = owner_q;
        idx = '0;
        if (bus.mode) begin
            for (int i = MASTERS - 1; i >= 0; i--) begin
                idx = OWNER_WIDTH'(i);
                if (others[idx]) next_owner = idx;
            end
        end else begin
            for (int k = MASTERS - 1; k >= 1; k--) begin
                idx = OWNER_WIDTH'((int'(owner_q) + k) % MASTERS);
                if (others[idx]) next_owner = idx;
            end
        end
    end

    always_comb begin
        owner_d   = owner_q;
        tenure_d  = '0;
        preempt_d = 1'b0;
        if (!owner_req)
            owner_d = next_owner;
        else if (owner_lock)
            tenure_d = (!contended || MAX_TENURE == 0) ? '0 : (tenure_q == LIM ? tenure_q : tenure_q + 1'b1);
        else if (contended && MAX_TENURE != 0 && tenure_q == LIM) begin
            owner_d   = next_owner;
            preempt_d = 1'b1;
        end else if (contended)
            tenure_d = tenure_q + 1'b1;
    end

    // Grant is registered from the next owner so it is a clean flop output.
    always_comb grant_d = ~(MASTERS'(1) << owner_d);

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q   <= '0;
            tenure_q  <= '0;
            preempt_q <= 1'b0;
            grant_q   <= ~MASTERS'(1);
        end else begin
            owner_q   <= owner_d;
            tenure_q  <= tenure_d;
            preempt_q <= preempt_d;
            grant_q   <= grant_d;
        end
    end

    assign bus.owner   = owner_q;
    assign bus.grant_  = grant_q;
    assign bus.preempt = preempt_q;
endmodule

// File: tb/tb_bus_arbiter_rr_n.sv
// tb_bus_arbiter_rr_n: directed vectors on a 4-master arbiter, model-checked random run on a 5-master one
module tb_bus_arbiter_rr_n;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_own = 0;
    int   m_ten = 0;
    logic m_pre = 1'b0;

    always #5 clock = ~clock;

    bus_arbiter_rr_n_if #(.MASTERS(4), .OWNER_WIDTH(2)) ba ();
    bus_arbiter_rr_n_if #(.MASTERS(5), .OWNER_WIDTH(3)) bb ();

    bus_arbiter_rr_n #(.MASTERS(4), .OWNER_WIDTH(2), .MAX_TENURE(4), .TENURE_WIDTH(3)) dut_a (
        .clock(clock), .reset(reset), .bus(ba.slave));
    bus_arbiter_rr_n #(.MASTERS(5), .OWNER_WIDTH(3), .MAX_TENURE(16), .TENURE_WIDTH(5)) dut_b (
        .clock(clock), .reset(reset), .bus(bb.slave));

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lck;
        logic       md;
        int         own;
        logic       pre;
    } vec_t;
    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic rst, input logic [3:0] req, input logic [3:0] lck, input logic md,
                           input int own, input logic pre, input string name);
        logic [3:0] g;
        reset = rst;
        ba.request_ = req;
        ba.lock_ = lck;
        ba.mode = md;
        @(posedge clock);
        #1;
        g = ~(4'b0001 << own);
        check({name, "_owner"}, 32'(ba.owner), 32'(own));
        check({name, "_grant"}, 32'(ba.grant_), 32'(g));
        check({name, "_preempt"}, 32'(ba.preempt), 32'(pre));
    endtask

    function automatic int pick(input logic [4:0] rq, input int own, input logic md);
        if (md) begin
            for (int j = 0; j < 5; j++) if (rq[j] && j != own) return j;
        end else begin
            for (int k = 1; k < 5; k++) if (rq[(own + k) % 5]) return (own + k) % 5;
        end
        return own;
    endfunction

    task automatic model_b(input logic rst, input logic [4:0] req, input logic [4:0] lck, input logic md);
        logic [4:0] rq, oth;
        rq = ~req;
        oth = rq & ~(5'b00001 << m_own);
        m_pre = 1'b0;
        if (rst) begin
            m_own = 0;
            m_ten = 0;
        end else if (!rq[m_own]) begin
            m_own = pick(rq, m_own, md);
            m_ten = 0;
        end else if (!lck[m_own]) begin
            m_ten = (oth == 0) ? 0 : (m_ten < 15 ? m_ten + 1 : 15);
        end else if (oth != 0 && m_ten == 15) begin
            m_own = pick(rq, m_own, md);
            m_ten = 0;
            m_pre = 1'b1;
        end else begin
            m_ten = (oth != 0) ? m_ten + 1 : 0;
        end
    endtask

    task automatic b_edge(input logic rst, input logic [4:0] req, input logic [4:0] lck, input logic md);
        logic [4:0] g;
        reset = rst;
        bb.request_ = req;
        bb.lock_ = lck;
        bb.mode = md;
        model_b(rst, req, lck, md);
        @(posedge clock);
        #1;
        g = ~(5'b00001 << m_own);
        check("b_owner", 32'(bb.owner), 32'(m_own));
        check("b_grant", 32'(bb.grant_), 32'(g));
        check("b_preempt", 32'(bb.preempt), 32'(m_pre));
        check("b_range", 32'(bb.owner < 3'd5), 32'(1));
    endtask

    initial begin
        logic [4:0] rq, lk;
        logic       md;
        ba.request_ = '1; ba.lock_ = '1; ba.mode = 1'b0;
        bb.request_ = '1; bb.lock_ = '1; bb.mode = 1'b0;

        // rst, request_, lock_, mode, expected owner, expected preempt
        tv.push_back('{1'b1, 4'b0000, 4'b1111, 1'b0, 0, 1'b0});
        tv.push_back('{1'b1, 4'b1010, 4'b1111, 1'b0, 0, 1'b0});
        tv.push_back('{1'b0, 4'b1101, 4'b1111, 1'b0, 1, 1'b0});
        tv.push_back('{1'b0, 4'b0011, 4'b1111, 1'b0, 2, 1'b0});
        tv.push_back('{1'b0, 4'b0111, 4'b1111, 1'b0, 3, 1'b0});
        tv.push_back('{1'b0, 4'b1110, 4'b1111, 1'b0, 0, 1'b0});
        tv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b0, 0, 1'b0});
        tv.push_back('{1'b0, 4'b1101, 4'b1111, 1'b0, 1, 1'b0});
        tv.push_back('{1'b0, 4'b1010, 4'b1111, 1'b1, 0, 1'b0});
        tv.push_back('{1'b0, 4'b1101, 4'b1111, 1'b0, 1, 1'b0});
        tv.push_back('{1'b0, 4'b1010, 4'b1111, 1'b0, 2, 1'b0});
        tv.push_back('{1'b0, 4'b1011, 4'b1111, 1'b0, 2, 1'b0});
        tv.push_back('{1'b1, 4'b1010, 4'b1111, 1'b0, 0, 1'b0});
        tv.push_back('{1'b0, 4'b1010, 4'b1111, 1'b0, 0, 1'b0});
        tv.push_back('{1'b0, 4'b1010, 4'b1111, 1'b0, 0, 1'b0});
        tv.push_back('{1'b0, 4'b1010, 4'b1111, 1'b0, 0, 1'b0});
        tv.push_back('{1'b0, 4'b1010, 4'b1111, 1'b0, 2, 1'b1});
        tv.push_back('{1'b0, 4'b1010, 4'b1111, 1'b0, 2, 1'b0});
        tv.push_back('{1'b0, 4'b1010, 4'b1111, 1'b0, 2, 1'b0});
        tv.push_back('{1'b0, 4'b1010, 4'b1111, 1'b0, 2, 1'b0});
        tv.push_back('{1'b0, 4'b1010, 4'b1111, 1'b0, 0, 1'b1});
        tv.push_back('{1'b0, 4'b1010, 4'b1011, 1'b0, 0, 1'b0});
        tv.push_back('{1'b0, 4'b1010, 4'b1011, 1'b0, 0, 1'b0});
        tv.push_back('{1'b0, 4'b1010, 4'b1011, 1'b0, 0, 1'b0});
        tv.push_back('{1'b0, 4'b1010, 4'b1011, 1'b0, 2, 1'b1});
        tv.push_back('{1'b0, 4'b1010, 4'b1011, 1'b0, 2, 1'b0});
        tv.push_back('{1'b0, 4'b0110, 4'b0111, 1'b0, 3, 1'b0});
        tv.push_back('{1'b0, 4'b0110, 4'b0111, 1'b0, 3, 1'b0});
        tv.push_back('{1'b1, 4'b0110, 4'b0111, 1'b0, 0, 1'b0});
        tv.push_back('{1'b1, 4'b0110, 4'b0111, 1'b0, 0, 1'b0});

        foreach (tv[v])
            drive_a(tv[v].rst, tv[v].req, tv[v].lck, tv[v].md, tv[v].own, tv[v].pre, $sformatf("v%0d", v));

        // Locked owner keeps the bus past the tenure limit; unlocking hands off at once.
        drive_a(1'b1, 4'b1010, 4'b1110, 1'b0, 0, 1'b0, "lock_rst");
        for (int c = 0; c < 20; c++) drive_a(1'b0, 4'b1010, 4'b1110, 1'b0, 0, 1'b0, $sformatf("lock_hold%0d", c));
        drive_a(1'b0, 4'b1010, 4'b1111, 1'b0, 2, 1'b1, "lock_release");
        drive_a(1'b0, 4'b1010, 4'b1111, 1'b0, 2, 1'b0, "lock_after");
        ba.request_ = '1;
        ba.lock_ = '1;

        // Five masters: wrap from owner 4 to 0, parking, then a long random run against the model.
        b_edge(1'b1, 5'b11111, 5'b11111, 1'b0);
        check("b5_reset", 32'(bb.grant_), 32'(5'b11110));
        b_edge(1'b0, 5'b01111, 5'b11111, 1'b0);
        check("b5_to4", 32'(bb.owner), 32'(4));
        b_edge(1'b0, 5'b11110, 5'b11111, 1'b0);
        check("b5_wrap", 32'(bb.owner), 32'(0));
        b_edge(1'b0, 5'b11111, 5'b11111, 1'b0);
        check("b5_park", 32'(bb.owner), 32'(0));
        rq = 5'b11111;
        md = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) rq = 5'($urandom);
            lk = 5'($urandom) | 5'($urandom) | 5'($urandom);
            if ($urandom_range(0, 63) == 0) md = ~md;
            b_edge($urandom_range(0, 999) == 0, rq, lk, md);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
